// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the RAM port arbiter:
//   - arb_state_t : transaction FSM states
//   - DEF_*       : default RAM geometry (19-bit word address, 128-bit data,
//                   16 byte enables)
//   - bus_slice() : extracts slice idx of a packed per-requester bus
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_BE_W   = 16;

    // bus_slice works on a bus zero-extended to the widest legal packed bus
    // (8 requesters of DEF_DATA_W bits). The caller truncates the result to
    // its own slice width.
    localparam int MAX_REQ     = 8;
    localparam int SLICE_MAX_W = DEF_DATA_W;
    localparam int BUS_MAX_W   = MAX_REQ * DEF_DATA_W;

    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   idx,
        input int                   width
    );
        logic [BUS_MAX_W-1:0] shifted_s;
        shifted_s = bus >> (idx * width);
        return shifted_s[SLICE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. The search starts one past
//   last_grant and wraps, so the previous winner has the lowest priority.
// Ports:
//   valid      in  N_REQ  per-requester request
//   last_grant in  IDX_W  index of the previous winner
//   any        out 1      at least one request is pending
//   grant_idx  out IDX_W  winner index (last_grant when nothing is pending)
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic             any,
    output logic [IDX_W-1:0] grant_idx
);

    // Rotate the request vector so bit 0 is the requester right after the
    // previous winner, then take the first set bit and map it back.
    always_comb begin
        logic [2*N_REQ-1:0] dbl_s;
        logic [N_REQ-1:0]   rot_s;
        logic               found_s;
        int                 win_s;
        dbl_s     = {valid, valid};
        rot_s     = N_REQ'(dbl_s >> (int'(last_grant) + 1));
        any       = |valid;
        grant_idx = last_grant;
        found_s   = 1'b0;
        win_s     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && rot_s[i]) begin
                win_s = int'(last_grant) + 1 + i;
                if (win_s >= N_REQ) begin
                    win_s = win_s - N_REQ;
                end else begin
                    win_s = win_s;
                end
                grant_idx = IDX_W'(win_s);
                found_s   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Round-robin sharing of the single read/write port of the data RAM among
//   N_REQ requesters. One access at a time: IDLE -> ACCESS -> (WAIT) -> DONE.
// Ports:
//   clock, async_reset          system clock, asynchronous active-high reset
//   req_valid/req_write         per-requester request and write flag
//   req_addr/req_wdata/req_be   packed per-requester address, data, enables
//   req_done                    one-hot one-cycle completion pulse
//   rsp_rdata                   read data, valid while req_done is set
//   busy                        high whenever the FSM is not in IDLE
//   ram_*                       RAM port A (address, write data, byte
//                               enables, write enable, read data)
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BE_W       = DEF_BE_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    async_reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    input  logic [N_REQ*BE_W-1:0]   req_be,
    output logic [N_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       ram_address,
    output logic [DATA_W-1:0]       ram_data_in,
    output logic [BE_W-1:0]         ram_byte_enablers,
    output logic                    ram_write_enable,
    input  logic [DATA_W-1:0]       ram_data_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 3;

    arb_state_t         state_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   grant_r;
    logic               write_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [DATA_W-1:0]  rdata_r;
    logic [N_REQ-1:0]   done_r;
    logic               busy_r;
    logic [ADDR_W-1:0]  ram_addr_r;
    logic [DATA_W-1:0]  ram_wdata_r;
    logic [BE_W-1:0]    ram_be_r;
    logic               ram_we_r;

    logic               any_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [DATA_W-1:0]  win_wdata_s;
    logic [BE_W-1:0]    win_be_s;
    logic               win_write_s;
    logic [N_REQ-1:0]   done_vec_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid      (req_valid),
        .last_grant (last_grant_r),
        .any        (any_s),
        .grant_idx  (grant_idx_s)
    );

    // Pull the round-robin winner's fields out of the packed request buses.
    always_comb begin
        win_addr_s  = ADDR_W'(bus_slice(BUS_MAX_W'(req_addr),  int'(grant_idx_s), ADDR_W));
        win_wdata_s = DATA_W'(bus_slice(BUS_MAX_W'(req_wdata), int'(grant_idx_s), DATA_W));
        win_be_s    = BE_W'(bus_slice(BUS_MAX_W'(req_be),      int'(grant_idx_s), BE_W));
        win_write_s = req_write[grant_idx_s];
        done_vec_s  = N_REQ'(1'b1) << grant_r;
    end

    // Transaction sequencer. The ram_* registers double as the latched
    // request: they are loaded when IDLE accepts a winner and held until
    // DONE, while write_r remembers the direction after the strobe drops.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_r      <= IDLE;
            last_grant_r <= IDX_W'(N_REQ - 1);
            grant_r      <= '0;
            write_r      <= 1'b0;
            wait_cnt_r   <= '0;
            rdata_r      <= '0;
            done_r       <= '0;
            busy_r       <= 1'b0;
            ram_addr_r   <= '0;
            ram_wdata_r  <= '0;
            ram_be_r     <= '0;
            ram_we_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        grant_r      <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        write_r      <= win_write_s;
                        ram_addr_r   <= win_addr_s;
                        ram_wdata_r  <= win_wdata_s;
                        ram_be_r     <= win_be_s;
                        ram_we_r     <= win_write_s;
                        busy_r       <= 1'b1;
                        state_r      <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    ram_we_r <= 1'b0;
                    if (write_r) begin
                        done_r  <= done_vec_s;
                        state_r <= DONE;
                    end else if (RD_LATENCY == 0) begin
                        // Zero-latency RAM: data is already valid during ACCESS.
                        rdata_r <= ram_data_out;
                        done_r  <= done_vec_s;
                        state_r <= DONE;
                    end else begin
                        wait_cnt_r <= CNT_W'(RD_LATENCY - 1);
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == '0) begin
                        rdata_r <= ram_data_out;
                        done_r  <= done_vec_s;
                        state_r <= DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - CNT_W'(1'b1);
                    end
                end
                DONE: begin
                    // req_valid is deliberately ignored here so a requester
                    // can retire its request on the done edge.
                    done_r      <= '0;
                    busy_r      <= 1'b0;
                    ram_addr_r  <= '0;
                    ram_wdata_r <= '0;
                    ram_be_r    <= '0;
                    state_r     <= IDLE;
                end
                default: begin
                    done_r      <= '0;
                    busy_r      <= 1'b0;
                    ram_we_r    <= 1'b0;
                    ram_addr_r  <= '0;
                    ram_wdata_r <= '0;
                    ram_be_r    <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign req_done          = done_r;
    assign rsp_rdata         = rdata_r;
    assign busy              = busy_r;
    assign ram_address       = ram_addr_r;
    assign ram_data_in       = ram_wdata_r;
    assign ram_byte_enablers = ram_be_r;
    assign ram_write_enable  = ram_we_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter. Three instances share clock and reset:
// index 0 has RD_LATENCY=1 (main tests), 1 has RD_LATENCY=0, 2 has 3.
// The RAM model drives valid read data only on the exact cycle a RAM with
// that latency would, and a garbage pattern otherwise.
module tb_ram_port_arbiter;

    localparam logic [127:0] GARBAGE = {8{16'hBAD0}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   req_valid_a   [3];
    logic [1:0]   req_write_a   [3];
    logic [37:0]  req_addr_a    [3];
    logic [255:0] req_wdata_a   [3];
    logic [31:0]  req_be_a      [3];
    logic [1:0]   req_done_a    [3];
    logic [127:0] rsp_rdata_a   [3];
    logic         busy_a        [3];
    logic [18:0]  ram_address_a [3];
    logic [127:0] ram_data_in_a [3];
    logic [15:0]  ram_be_a      [3];
    logic         ram_we_a      [3];
    logic [127:0] ram_data_out_a[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_port_arbiter #(
            .N_REQ      (2),
            .ADDR_W     (19),
            .DATA_W     (128),
            .BE_W       (16),
            .RD_LATENCY ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) dut (
            .clock             (clk),
            .async_reset       (rst),
            .req_valid         (req_valid_a[g]),
            .req_write         (req_write_a[g]),
            .req_addr          (req_addr_a[g]),
            .req_wdata         (req_wdata_a[g]),
            .req_be            (req_be_a[g]),
            .req_done          (req_done_a[g]),
            .rsp_rdata         (rsp_rdata_a[g]),
            .busy              (busy_a[g]),
            .ram_address       (ram_address_a[g]),
            .ram_data_in       (ram_data_in_a[g]),
            .ram_byte_enablers (ram_be_a[g]),
            .ram_write_enable  (ram_we_a[g]),
            .ram_data_out      (ram_data_out_a[g])
        );
    end

    // ---------------- RAM model ----------------
    logic [127:0] wmem   [16];
    logic         wvalid [16];
    logic [18:0]  wtag   [16];
    logic [18:0]  prev_addr [3];
    logic [7:0]   v_pipe    [3];
    logic [127:0] d_pipe    [3][8];
    logic         fresh     [3];

    function automatic logic [127:0] ram_default(input logic [18:0] a);
        if (a == 19'h00010) return 128'hDEADBEEF_00000000_00000000_00000001;
        else return {32'hCAFEF00D, 77'd0, a};
    endfunction

    function automatic logic [127:0] ram_read(input logic [18:0] a);
        if (wvalid[a[3:0]] && wtag[a[3:0]] == a) return wmem[a[3:0]];
        else return ram_default(a);
    endfunction

    function automatic logic [127:0] byte_merge(input logic [127:0] old_w,
                                                input logic [127:0] new_w,
                                                input logic [15:0] be);
        logic [127:0] r;
        r = old_w;
        for (int b = 0; b < 16; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            prev_addr[k] <= rst ? 19'd0 : ram_address_a[k];
            v_pipe[k]    <= rst ? 8'd0 : {v_pipe[k][6:0], fresh[k]};
            d_pipe[k][0] <= ram_read(ram_address_a[k]);
            for (int j = 1; j < 8; j++) d_pipe[k][j] <= d_pipe[k][j-1];
        end
        for (int s = 0; s < 16; s++) if (rst) wvalid[s] <= 1'b0;
        if (!rst && ram_we_a[0]) begin
            wmem[ram_address_a[0][3:0]]   <= byte_merge(ram_read(ram_address_a[0]),
                                                        ram_data_in_a[0], ram_be_a[0]);
            wvalid[ram_address_a[0][3:0]] <= 1'b1;
            wtag[ram_address_a[0][3:0]]   <= ram_address_a[0];
        end
    end

    // An access starts on the first cycle with a nonzero address after IDLE.
    always_comb begin
        int lat_k;
        for (int k = 0; k < 3; k++) begin
            lat_k = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
            fresh[k] = (ram_address_a[k] != 19'd0) && (prev_addr[k] == 19'd0);
            ram_data_out_a[k] = GARBAGE;
            if (lat_k == 0) begin
                if (fresh[k]) ram_data_out_a[k] = ram_read(ram_address_a[k]);
            end else if (v_pipe[k][lat_k-1]) begin
                ram_data_out_a[k] = d_pipe[k][lat_k-1];
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int k, input int r, input logic wr, input logic [18:0] a,
                           input logic [127:0] wd, input logic [15:0] be,
                           output logic [1:0] done, output logic [127:0] rd, output int lat,
                           output int we_n, output logic [18:0] we_a, output logic [15:0] we_be);
        @(negedge clk);
        req_write_a[k][r]            = wr;
        req_addr_a[k][r*19 +: 19]    = a;
        req_wdata_a[k][r*128 +: 128] = wd;
        req_be_a[k][r*16 +: 16]      = be;
        req_valid_a[k][r]            = 1'b1;
        lat = 0; we_n = 0; done = 2'b00; rd = '0; we_a = '0; we_be = '0;
        while (lat < 20 && done == 2'b00) begin
            @(negedge clk);
            lat++;
            if (ram_we_a[k]) begin
                we_n++;
                we_a  = ram_address_a[k];
                we_be = ram_be_a[k];
            end
            if (req_done_a[k] != 2'b00) begin
                done = req_done_a[k];
                rd   = rsp_rdata_a[k];
            end
        end
        req_valid_a[k][r] = 1'b0;
    endtask

    typedef struct {
        int           req;
        logic         wr;
        logic [18:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  be;
        logic [1:0]   exp_done;
        logic [127:0] exp_rdata;
        int           exp_lat;
        int           exp_we;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0]   done;
        logic [127:0] rd;
        int           lat, we_n, cnt0, cnt1, ndone, r0_dones, cyc;
        logic [18:0]  we_a;
        logic [15:0]  we_be;
        logic [1:0]   seen_first;

        vecs[0] = '{0, 1'b0, 19'h00010, 128'd0, 16'hFFFF, 2'b01,
                    128'hDEADBEEF_00000000_00000000_00000001, 3, 0};
        vecs[1] = '{1, 1'b1, 19'h7FFFF, 128'h11223344, 16'h000F, 2'b10, 128'd0, 2, 1};
        vecs[2] = '{0, 1'b0, 19'h7FFFF, 128'd0, 16'hFFFF, 2'b01,
                    128'hCAFEF00D_00000000_00000000_11223344, 3, 0};
        vecs[3] = '{1, 1'b0, 19'h00ABC, 128'd0, 16'hFFFF, 2'b10,
                    128'hCAFEF00D_00000000_00000000_00000ABC, 3, 0};
        vecs[4] = '{0, 1'b1, 19'h00023, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
                    16'hF0F0, 2'b01, 128'd0, 2, 1};
        vecs[5] = '{1, 1'b0, 19'h00023, 128'd0, 16'hFFFF, 2'b10,
                    128'hA5A5A5A5_00000000_A5A5A5A5_00000023, 3, 0};

        for (int k = 0; k < 3; k++) begin
            req_valid_a[k] = '0; req_write_a[k] = '0; req_addr_a[k] = '0;
            req_wdata_a[k] = '0; req_be_a[k] = '0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset req_done",  128'(req_done_a[0]), 128'd0);
        check("reset rsp_rdata", rsp_rdata_a[0], 128'd0);
        check("reset busy",      128'(busy_a[0]), 128'd0);
        check("reset ram_addr",  128'(ram_address_a[0]), 128'd0);
        check("reset ram_data",  ram_data_in_a[0], 128'd0);
        check("reset ram_be",    128'(ram_be_a[0]), 128'd0);
        check("reset ram_we",    128'(ram_we_a[0]), 128'd0);

        // Table-driven single transactions on the RD_LATENCY=1 instance
        for (int i = 0; i < 6; i++) begin
            run_txn(0, vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    done, rd, lat, we_n, we_a, we_be);
            check($sformatf("v%0d done", i),    128'(done), 128'(vecs[i].exp_done));
            check($sformatf("v%0d latency", i), 128'(lat),  128'(vecs[i].exp_lat));
            check($sformatf("v%0d we_cycles", i), 128'(we_n), 128'(vecs[i].exp_we));
            if (vecs[i].wr) begin
                check($sformatf("v%0d we_addr", i), 128'(we_a),  128'(vecs[i].addr));
                check($sformatf("v%0d we_be", i),   128'(we_be), 128'(vecs[i].be));
            end else begin
                check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        // Latency sweep: RD_LATENCY=0 and 3
        run_txn(1, 0, 1'b0, 19'h00040, 128'd0, 16'hFFFF, done, rd, lat, we_n, we_a, we_be);
        check("lat0 done",    128'(done), 128'(2'b01));
        check("lat0 latency", 128'(lat),  128'd2);
        check("lat0 rdata",   rd, 128'hCAFEF00D_00000000_00000000_00000040);
        run_txn(2, 0, 1'b0, 19'h00040, 128'd0, 16'hFFFF, done, rd, lat, we_n, we_a, we_be);
        check("lat3 done",    128'(done), 128'(2'b01));
        check("lat3 latency", 128'(lat),  128'd5);
        check("lat3 rdata",   rd, 128'hCAFEF00D_00000000_00000000_00000040);

        // Early drop: requester 0 withdraws during WAIT, requester 1 arrives
        @(negedge clk);
        req_write_a[0] = 2'b00;
        req_addr_a[0]  = {19'h00ABC, 19'h00010};
        req_valid_a[0] = 2'b01;
        @(negedge clk);                  // ACCESS
        @(negedge clk);                  // WAIT
        check("drop in wait busy", 128'(busy_a[0]), 128'd1);
        req_valid_a[0] = 2'b10;
        r0_dones = 0; ndone = 0; seen_first = 2'b00; cyc = 0;
        while (cyc < 30 && ndone < 2) begin
            @(negedge clk);
            cyc++;
            if (req_done_a[0] != 2'b00) begin
                if (req_done_a[0][0]) r0_dones++;
                if (ndone == 0) begin
                    seen_first = req_done_a[0];
                    check("drop r0 rdata", rsp_rdata_a[0], 128'hDEADBEEF_00000000_00000000_00000001);
                end else begin
                    check("drop next grant", 128'(req_done_a[0]), 128'(2'b10));
                    req_valid_a[0] = 2'b00;
                end
                ndone++;
            end
        end
        check("drop first done", 128'(seen_first), 128'(2'b01));
        check("drop r0 done count", 128'(r0_dones), 128'd1);
        check("drop total dones", 128'(ndone), 128'd2);

        // Contention from reset: both requesters reading, 6 each
        @(negedge clk);
        rst = 1'b1;
        req_valid_a[0] = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        cnt0 = 0; cnt1 = 0; ndone = 0; cyc = 0;
        while (cyc < 200 && ndone < 12) begin
            @(negedge clk);
            cyc++;
            if (req_done_a[0] != 2'b00) begin
                check($sformatf("contend grant %0d", ndone), 128'(req_done_a[0]),
                      (ndone % 2 == 0) ? 128'd1 : 128'd2);
                if (req_done_a[0][1]) begin
                    cnt1++;
                    check("contend r1 rdata", rsp_rdata_a[0], 128'hCAFEF00D_00000000_00000000_00000ABC);
                    if (cnt1 == 6) req_valid_a[0][1] = 1'b0;
                end else begin
                    cnt0++;
                    check("contend r0 rdata", rsp_rdata_a[0], 128'hDEADBEEF_00000000_00000000_00000001);
                    if (cnt0 == 6) req_valid_a[0][0] = 1'b0;
                end
                ndone++;
            end
        end
        req_valid_a[0] = 2'b00;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (req_done_a[0] != 2'b00) ndone++;
        end
        check("contend r0 count", 128'(cnt0), 128'd6);
        check("contend r1 count", 128'(cnt1), 128'd6);
        check("contend extra dones", 128'(ndone), 128'd0);

        // Reset during a write ACCESS
        @(negedge clk);
        req_write_a[0] = 2'b01;
        req_addr_a[0]  = {19'h00ABC, 19'h00055};
        req_wdata_a[0] = '1;
        req_be_a[0]    = '1;
        req_valid_a[0] = 2'b01;
        @(negedge clk);                  // ACCESS
        check("midrst we before", 128'(ram_we_a[0]), 128'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst we async drop", 128'(ram_we_a[0]), 128'd0);
        check("midrst busy",          128'(busy_a[0]), 128'd0);
        req_valid_a[0] = 2'b00;
        req_write_a[0] = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (req_done_a[0] != 2'b00) ndone++;
        end
        check("midrst no done", 128'(ndone), 128'd0);
        req_addr_a[0]  = {19'h00ABC, 19'h00010};
        req_valid_a[0] = 2'b11;
        ndone = 0; cyc = 0;
        while (cyc < 30 && ndone < 2) begin
            @(negedge clk);
            cyc++;
            if (req_done_a[0] != 2'b00) begin
                check($sformatf("midrst grant %0d", ndone), 128'(req_done_a[0]),
                      (ndone == 0) ? 128'd1 : 128'd2);
                req_valid_a[0] = req_valid_a[0] & ~req_done_a[0];
                ndone++;
            end
        end
        check("midrst dones after release", 128'(ndone), 128'd2);
        req_valid_a[0] = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
